// File: rtl/seq_divider_if.sv
// Start/done handshake bundle between the DIV control sequencer and seq_divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic [2*WIDTH-1:0] z_out;
  logic               div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, z_out, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, z_out, div_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock, WIDTH+1 clock latency.
// Define DIV_SIGNED_EN for two's complement operands; default build is unsigned.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          clr,
  seq_divider_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dzo_q, dzo_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;

  // Operand signs and magnitudes as seen at accept time
`ifdef DIV_SIGNED_EN
  assign a_neg = bus.dividend[WIDTH-1];
  assign b_neg = bus.divisor[WIDTH-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif
  assign a_mag = a_neg ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
  assign b_mag = b_neg ? (~bus.divisor + WIDTH'(1)) : bus.divisor;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dzo_d   = dzo_q;
    // rem stays below the divisor, so bit WIDTH of diff is the borrow
    shifted = {rem_q, dq_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dq_d    = a_mag;
          dvs_d   = b_mag;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = (bus.divisor == '0);
          rem_d   = '0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          dq_d  = {dq_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          dq_d  = {dq_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // Zero divisor leaves |dividend| in rem, so the sign fix restores it exactly
        if (dz_q) begin
          quo_d = '1;
        end else begin
          quo_d = qneg_q ? (~dq_q + WIDTH'(1)) : dq_q;
        end
        rmd_d   = rneg_q ? (~rem_q + WIDTH'(1)) : rem_q;
        dzo_d   = dz_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dzo_q   <= dzo_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rmd_q;
  assign bus.z_out     = {rmd_q, quo_q};
  assign bus.div_zero  = dzo_q;

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle 32-bit divider responding to the DIV control sequence of the CPU datapath. Operands arrive from the Y register (dividend) and the bus (divisor) on a start strobe. The unit iterates one quotient bit per clock and returns a 64-bit result, remainder in the high half and quotient in the low half, for loading into ZHI/ZLO and then HI/LO. It replaces the combinational divide path in the ALU with a start/done handshake.

## Interface
- WIDTH, 32: operand width; result is 2*WIDTH.
- clk  in  1  clock, all state on rising edge
- clr  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- dividend  in  WIDTH  numerator (Y register)
- divisor  in  WIDTH  denominator (bus)
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse; results valid in this cycle and held after it
- quotient  out  WIDTH  ZLO value
- remainder  out  WIDTH  ZHI value
- z_out  out  2*WIDTH  {remainder, quotient}
- div_zero  out  1  set with done when divisor was 0; held with results

## Operation
- States: IDLE, ITER, FIX.
- IDLE:
  - start=1: capture |dividend|, |divisor| and operand signs; clear partial remainder; count<=0; busy<=1; go to ITER.
  - start=0: stay in IDLE.
- ITER, restoring algorithm, one bit per cycle:
  - Shift {rem, dq} left one bit.
  - Trial subtract rem - |divisor|.
  - Non-negative: keep the difference and set quotient bit to 1. Negative: restore and set the bit to 0.
  - After WIDTH iterations, go to FIX.
- FIX:
  - Apply signs: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Register quotient, remainder, z_out and div_zero.
  - done<=1 for one cycle, busy<=0, go to IDLE.
- Arithmetic rules:
  - Quotient truncates toward zero. Results are WIDTH bits, two's complement wrap, no saturation.
  - Most-negative / -1: quotient=0x80000000, remainder=0, no flag.
  - Divisor 0: quotient=all ones, remainder=dividend unmodified, div_zero=1. Full latency is still taken.
- start while busy: ignored, no queueing, current operation unaffected.
- Operands are latched at accept; changes to dividend/divisor afterwards have no effect.
- Outputs hold their last result until the next FIX overwrites them. They do not clear at start.

## Timing
- Reset (clr low, asynchronous): state=IDLE, count=0, busy=0, done=0, quotient=0, remainder=0, z_out=0, div_zero=0.
- Reset mid-operation aborts the operation; no done pulse follows.
- Start sampled high at edge E0:
  - busy rises after E0.
  - ITER occupies edges E1..E32.
  - FIX registers results at E33; done is high for the cycle after E33.
  - Latency is WIDTH+1 clocks, fixed regardless of operand values.
- busy falls in the same edge that raises done.
- New start is accepted in the done cycle itself, since the state is already IDLE. Back-to-back throughput is one operation per WIDTH+1 clocks.
- Controller sequencing: assert start in the T4-equivalent step, wait for done, then transfer z_out to ZHI/ZLO.

## Configuration
- DIV_SIGNED_EN defined: operands are two's complement and sign handling in IDLE/FIX is active as described.
- DIV_SIGNED_EN undefined:
  - Operands are unsigned and FIX applies no sign correction.
  - Most-negative / -1 gives quotient=0, remainder=0x80000000 (unsigned 0x80000000 / 0xFFFFFFFF).
  - Divide-by-zero behaviour, latency and ports are unchanged.

## Test plan
- Dividend 0x0000000F, divisor 0x00000004, start -> done exactly 33 clocks later; quotient=3, remainder=3, z_out=0x00000003_00000003, div_zero=0.
- Signed build, dividend 0xFFFFFFF1 (-15), divisor 4 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFD. Unsigned build, same operands -> quotient=0x3FFFFFFC, remainder=1.
- Divisor 0, dividend 0x12 -> after 33 clocks quotient=0xFFFFFFFF, remainder=0x12, div_zero=1.
- Signed build, 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_zero=0.
- 100/7 started, second start with 9/3 pulsed at clock 10 -> single done at clock 33 with quotient=14, remainder=2. A new start of 9/3 in the done cycle -> quotient=3, remainder=0, 33 clocks later.
- clr driven low at clock 15 of 0xFF/0x10 -> busy=0, outputs 0 immediately, no done pulse. A fresh 0xFF/0x10 then yields quotient=0xF, remainder=0xF.
